// File: rtl/alu_rs_sched_pkg.sv
// Shared widths, bus payloads and the reservation-station entry layout for
// the ALU reservation-station scheduler.
//   cdb_t       : one result broadcast (valid, tag, value)
//   operand_t   : one source operand (pending flag, producing tag, value)
//   rs_entry_t  : one reservation-station slot
//   alu_issue_t : payload handed to the ALU on issue
package alu_rs_sched_pkg;

   localparam int unsigned RS_SIZE  = 16;
   localparam int unsigned ROB_ID_W = 4;
   localparam int unsigned OP_ID_W  = 6;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RS_IDX_W = $clog2(RS_SIZE);

   typedef struct packed {
      logic                valid;
      logic [ROB_ID_W-1:0] rob_id;
      logic [DATA_W-1:0]   value;
   } cdb_t;

   typedef struct packed {
      logic                busy;
      logic [ROB_ID_W-1:0] q;
      logic [DATA_W-1:0]   v;
   } operand_t;

   typedef struct packed {
      logic                valid;
      logic [OP_ID_W-1:0]  op;
      logic [DATA_W-1:0]   pc;
      operand_t            j;
      operand_t            k;
      logic [DATA_W-1:0]   imm;
      logic [ROB_ID_W-1:0] rob_id;
   } rs_entry_t;

   typedef struct packed {
      logic [OP_ID_W-1:0]  op;
      logic [DATA_W-1:0]   pc;
      logic [DATA_W-1:0]   rs1;
      logic [DATA_W-1:0]   rs2;
      logic [DATA_W-1:0]   imm;
      logic [ROB_ID_W-1:0] rob_id;
   } alu_issue_t;

   // Resolve a pending operand against both broadcast buses; cdb0 wins a tie.
   function automatic operand_t snoop(operand_t o, cdb_t c0, cdb_t c1);
      operand_t r;
      r = o;
      if (o.busy) begin
         if (c0.valid && (c0.rob_id == o.q)) begin
            r.busy = 1'b0;
            r.v    = c0.value;
         end else if (c1.valid && (c1.rob_id == o.q)) begin
            r.busy = 1'b0;
            r.v    = c1.value;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_rs_sched_prio_enc.sv
// Lowest-index priority encoder.
//   req     : request vector
//   found_c : at least one request set (combinational)
//   idx_c   : index of the lowest set request, 0 when none (combinational)
module rs_prio_enc #(
   parameter  int unsigned N  = 16,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   output logic          found_c,
   output logic [IW-1:0] idx_c
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found_c = 1'b1;
            idx_c   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/alu_rs_sched.sv
// Reservation-station scheduler in front of the single-cycle ALU.
// Holds dispatched ops, resolves operand tags from two result buses, and
// issues at most one ready entry per cycle, lowest slot index first.
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global enable, low freezes the station
//   flush             : misprediction clear from the ROB
//   disp_*            : dispatch request and op payload
//   full              : all slots occupied (combinational from state)
//   cdb0_*, cdb1_*    : result broadcast buses
//   alu_*             : registered issue strobe and operands
module alu_rs_sched
   import alu_rs_sched_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                flush,
   input  logic                disp_valid,
   input  logic [OP_ID_W-1:0]  disp_op,
   input  logic [DATA_W-1:0]   disp_pc,
   input  logic [DATA_W-1:0]   disp_vj,
   input  logic [DATA_W-1:0]   disp_vk,
   input  logic                disp_qj_busy,
   input  logic                disp_qk_busy,
   input  logic [ROB_ID_W-1:0] disp_qj,
   input  logic [ROB_ID_W-1:0] disp_qk,
   input  logic [DATA_W-1:0]   disp_imm,
   input  logic [ROB_ID_W-1:0] disp_rob_id,
   output logic                full,
   input  logic                cdb0_valid,
   input  logic [ROB_ID_W-1:0] cdb0_rob_id,
   input  logic [DATA_W-1:0]   cdb0_value,
   input  logic                cdb1_valid,
   input  logic [ROB_ID_W-1:0] cdb1_rob_id,
   input  logic [DATA_W-1:0]   cdb1_value,
   output logic                alu_valid,
   output logic [OP_ID_W-1:0]  alu_op,
   output logic [DATA_W-1:0]   alu_pc,
   output logic [DATA_W-1:0]   alu_rs1,
   output logic [DATA_W-1:0]   alu_rs2,
   output logic [DATA_W-1:0]   alu_imm,
   output logic [ROB_ID_W-1:0] alu_rob_id
);

   rs_entry_t           entries     [RS_SIZE];
   rs_entry_t           entries_nxt [RS_SIZE];
   logic [RS_SIZE-1:0]  free_vec;
   logic [RS_SIZE-1:0]  ready_vec;
   logic                free_found;
   logic                ready_found;
   logic [RS_IDX_W-1:0] free_idx;
   logic [RS_IDX_W-1:0] ready_idx;
   logic                accept;
   cdb_t                cdb0;
   cdb_t                cdb1;
   alu_issue_t          issue_q;

   assign cdb0 = '{valid: cdb0_valid, rob_id: cdb0_rob_id, value: cdb0_value};
   assign cdb1 = '{valid: cdb1_valid, rob_id: cdb1_rob_id, value: cdb1_value};

   // Free/ready masks come from registered state only, so a same-cycle wakeup
   // or issue never affects this cycle's selection or allocation.
   always_comb begin
      free_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
         free_vec[i]  = !entries[i].valid;
         ready_vec[i] = entries[i].valid && !entries[i].j.busy && !entries[i].k.busy;
      end
   end

   rs_prio_enc #(.N(RS_SIZE)) u_free_enc (
      .req     (free_vec),
      .found_c (free_found),
      .idx_c   (free_idx)
   );

   rs_prio_enc #(.N(RS_SIZE)) u_ready_enc (
      .req     (ready_vec),
      .found_c (ready_found),
      .idx_c   (ready_idx)
   );

   assign full   = !free_found;
   assign accept = disp_valid && free_found;

   // Next entry state: flush clears, freeze holds, otherwise wake/issue/dispatch.
   // The issued slot is still valid in registered state, so it can never be
   // the allocated slot in the same cycle.
   always_comb begin
      entries_nxt = entries;
      if (flush) begin
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            entries_nxt[i].valid = 1'b0;
         end
      end else if (rdy) begin
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (entries[i].valid) begin
               entries_nxt[i].j = snoop(entries[i].j, cdb0, cdb1);
               entries_nxt[i].k = snoop(entries[i].k, cdb0, cdb1);
            end
         end
         if (ready_found) begin
            entries_nxt[ready_idx].valid = 1'b0;
         end
         if (accept) begin
            entries_nxt[free_idx] = '{
               valid:  1'b1,
               op:     disp_op,
               pc:     disp_pc,
               j:      snoop('{busy: disp_qj_busy, q: disp_qj, v: disp_vj}, cdb0, cdb1),
               k:      snoop('{busy: disp_qk_busy, q: disp_qk, v: disp_vk}, cdb0, cdb1),
               imm:    disp_imm,
               rob_id: disp_rob_id
            };
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(RS_SIZE); i++) begin
            entries[i] <= entries_nxt[i];
         end
      end
   end

   // Issue register: operands are only reloaded on an actual issue.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_valid <= 1'b0;
         issue_q   <= '0;
      end else if (flush || !rdy) begin
         alu_valid <= 1'b0;
      end else begin
         alu_valid <= ready_found;
         if (ready_found) begin
            issue_q <= '{
               op:     entries[ready_idx].op,
               pc:     entries[ready_idx].pc,
               rs1:    entries[ready_idx].j.v,
               rs2:    entries[ready_idx].k.v,
               imm:    entries[ready_idx].imm,
               rob_id: entries[ready_idx].rob_id
            };
         end
      end
   end

   assign alu_op     = issue_q.op;
   assign alu_pc     = issue_q.pc;
   assign alu_rs1    = issue_q.rs1;
   assign alu_rs2    = issue_q.rs2;
   assign alu_imm    = issue_q.imm;
   assign alu_rob_id = issue_q.rob_id;

endmodule

// File: tb/tb_alu_rs_sched.sv
// Self-checking bench for alu_rs_sched: directed scenarios followed by random
// traffic, with a slot-array reference model feeding an issue scoreboard.
module tb_alu_rs_sched;
   import alu_rs_sched_pkg::*;

   localparam int unsigned CW = 138;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        disp_valid, disp_qj_busy, disp_qk_busy;
   logic [5:0]  disp_op;
   logic [31:0] disp_pc, disp_vj, disp_vk, disp_imm;
   logic [3:0]  disp_qj, disp_qk, disp_rob_id;
   logic        full;
   logic        cdb0_valid, cdb1_valid;
   logic [3:0]  cdb0_rob_id, cdb1_rob_id;
   logic [31:0] cdb0_value, cdb1_value;
   logic        alu_valid;
   logic [5:0]  alu_op;
   logic [31:0] alu_pc, alu_rs1, alu_rs2, alu_imm;
   logic [3:0]  alu_rob_id;

   always #5 clk = ~clk;

   alu_rs_sched dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
      .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
      .disp_qj(disp_qj), .disp_qk(disp_qk),
      .disp_imm(disp_imm), .disp_rob_id(disp_rob_id), .full(full),
      .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
      .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
      .alu_valid(alu_valid), .alu_op(alu_op), .alu_pc(alu_pc),
      .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm),
      .alu_rob_id(alu_rob_id)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int            cyc;
      logic [CW-1:0] data;
   } exp_t;
   exp_t          sb[$];
   logic [CW-1:0] last_exp = '0;

   // Reference model: one record per slot.
   bit          m_valid [16];
   bit          m_jb [16];
   bit          m_kb [16];
   logic [3:0]  m_qj [16];
   logic [3:0]  m_qk [16];
   logic [3:0]  m_rob [16];
   logic [5:0]  m_op [16];
   logic [31:0] m_pc [16];
   logic [31:0] m_vj [16];
   logic [31:0] m_vk [16];
   logic [31:0] m_imm [16];

   task automatic chk(string name, logic [CW-1:0] act, logic [CW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [32:0] snoop_m(logic b, logic [3:0] q, logic [31:0] v);
      if (b && cdb0_valid && cdb0_rob_id == q) return {1'b0, cdb0_value};
      if (b && cdb1_valid && cdb1_rob_id == q) return {1'b0, cdb1_value};
      return {b, v};
   endfunction

   function automatic logic model_full();
      for (int i = 0; i < 16; i++) if (!m_valid[i]) return 1'b0;
      return 1'b1;
   endfunction

   // Apply one clock edge of the specified behaviour to the model.
   task automatic model_step();
      int   sel;
      int   fr;
      exp_t e;
      cyc++;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
         last_exp = '0;
      end else if (flush) begin
         for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end else if (rdy) begin
         sel = -1;
         fr  = -1;
         for (int i = 15; i >= 0; i--) begin
            if (m_valid[i] && !m_jb[i] && !m_kb[i]) sel = i;
            if (!m_valid[i]) fr = i;
         end
         for (int i = 0; i < 16; i++) begin
            if (m_valid[i]) begin
               {m_jb[i], m_vj[i]} = snoop_m(m_jb[i], m_qj[i], m_vj[i]);
               {m_kb[i], m_vk[i]} = snoop_m(m_kb[i], m_qk[i], m_vk[i]);
            end
         end
         if (sel >= 0) begin
            e.cyc  = cyc;
            e.data = {m_op[sel], m_pc[sel], m_vj[sel], m_vk[sel], m_imm[sel], m_rob[sel]};
            sb.push_back(e);
            last_exp     = e.data;
            m_valid[sel] = 1'b0;
         end
         if (disp_valid && fr >= 0) begin
            m_valid[fr] = 1'b1;
            m_op[fr]    = disp_op;
            m_pc[fr]    = disp_pc;
            m_imm[fr]   = disp_imm;
            m_rob[fr]   = disp_rob_id;
            m_qj[fr]    = disp_qj;
            m_qk[fr]    = disp_qk;
            {m_jb[fr], m_vj[fr]} = snoop_m(disp_qj_busy, disp_qj, disp_vj);
            {m_kb[fr], m_vk[fr]} = snoop_m(disp_qk_busy, disp_qk, disp_vk);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle();
      rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0;
      cdb0_valid = 1'b0; cdb1_valid = 1'b0;
   endtask

   task automatic disp(logic [5:0] op, logic [31:0] pc, logic [31:0] vj, logic [31:0] vk,
                       logic jb, logic [3:0] qj, logic kb, logic [3:0] qk,
                       logic [31:0] imm, logic [3:0] rob);
      disp_valid = 1'b1; disp_op = op; disp_pc = pc; disp_vj = vj; disp_vk = vk;
      disp_qj_busy = jb; disp_qj = qj; disp_qk_busy = kb; disp_qk = qk;
      disp_imm = imm; disp_rob_id = rob;
   endtask

   task automatic cdb0(logic [3:0] t, logic [31:0] v);
      cdb0_valid = 1'b1; cdb0_rob_id = t; cdb0_value = v;
   endtask

   task automatic cdb1(logic [3:0] t, logic [31:0] v);
      cdb1_valid = 1'b1; cdb1_rob_id = t; cdb1_value = v;
   endtask

   // Scoreboard monitor: pops the expected issue whenever the DUT strobes.
   initial begin : monitor
      logic [CW-1:0] got;
      exp_t          e;
      forever begin
         @(negedge clk);
         got = {alu_op, alu_pc, alu_rs1, alu_rs2, alu_imm, alu_rob_id};
         if (alu_valid === 1'b1) begin
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
               chk("issue_unexpected", CW'(1), CW'(0));
            end else begin
               e = sb.pop_front();
               chk("issue_payload", got, e.data);
            end
         end else begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
               void'(sb.pop_front());
               chk("issue_missing", CW'(0), CW'(1));
            end
            chk("alu_valid_low", CW'(alu_valid), CW'(0));
            chk("alu_data_hold", got, last_exp);
         end
         chk("full", CW'(full), CW'(model_full()));
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      disp_op = '0; disp_pc = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0;
      disp_qj_busy = 1'b0; disp_qk_busy = 1'b0; disp_qj = '0; disp_qk = '0; disp_rob_id = '0;
      cdb0_rob_id = '0; cdb0_value = '0; cdb1_rob_id = '0; cdb1_value = '0;
      repeat (2) tick();
      chk("rst_alu_valid", CW'(alu_valid), CW'(0));
      chk("rst_full", CW'(full), CW'(0));
      chk("rst_alu_rs1", CW'(alu_rs1), CW'(0));
      chk("rst_alu_rob", CW'(alu_rob_id), CW'(0));
      rst = 1'b0;
      tick();

      // Both operands ready: issue two edges after dispatch.
      disp(6'h01, 32'h100, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 32'h11, 4'd3);
      tick(); idle();
      chk("s1_not_early", CW'(alu_valid), CW'(0));
      tick();
      chk("s1_valid", CW'(alu_valid), CW'(1));
      chk("s1_rs1", CW'(alu_rs1), CW'(5));
      chk("s1_rs2", CW'(alu_rs2), CW'(7));
      chk("s1_rob", CW'(alu_rob_id), CW'(3));
      tick();
      chk("s1_freed", CW'(full), CW'(0));

      // Pending qj resolved by cdb1.
      disp(6'h02, 32'h104, 32'd0, 32'd1, 1'b1, 4'd6, 1'b0, 4'd0, 32'h0, 4'd4);
      tick(); idle();
      tick(); tick();
      chk("s2_wait", CW'(alu_valid), CW'(0));
      cdb1(4'd6, 32'hDEADBEEF);
      tick(); idle();
      chk("s2_wake_no_issue", CW'(alu_valid), CW'(0));
      tick();
      chk("s2_valid", CW'(alu_valid), CW'(1));
      chk("s2_rs1", CW'(alu_rs1), CW'(32'hDEADBEEF));

      // Dispatch bypass from cdb0.
      disp(6'h03, 32'h108, 32'd0, 32'd2, 1'b1, 4'd2, 1'b0, 4'd0, 32'h0, 4'd5);
      cdb0(4'd2, 32'd9);
      tick(); idle();
      tick();
      chk("s3_valid", CW'(alu_valid), CW'(1));
      chk("s3_rs1", CW'(alu_rs1), CW'(9));

      // Fill every slot with an unresolved op.
      for (int i = 0; i < 16; i++) begin
         disp(6'(i), 32'(i * 4), 32'd0, 32'(i), 1'b1, 4'(i), 1'b0, 4'd0, 32'(i), 4'(i));
         tick();
      end
      idle();
      chk("s4_full", CW'(full), CW'(1));
      disp(6'h3F, 32'hFFFF, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd15);
      tick(); idle();
      tick();
      chk("s4_overflow_dropped", CW'(alu_valid), CW'(0));
      cdb0(4'd0, 32'h55);
      tick(); idle();
      chk("s4_full_until_issue", CW'(full), CW'(1));
      tick();
      chk("s4_slot0_issue", CW'(alu_rob_id), CW'(0));
      chk("s4_full_drops", CW'(full), CW'(0));

      // Two wakeups in one cycle: lower slot first.
      cdb0(4'd5, 32'h5); cdb1(4'd2, 32'h2);
      tick(); idle();
      tick();
      chk("s5_first", CW'(alu_rob_id), CW'(2));
      tick();
      chk("s5_second", CW'(alu_rob_id), CW'(5));

      // Build four ready entries, freeze, then flush.
      cdb0(4'd7, 32'h7); cdb1(4'd8, 32'h8);
      tick(); cdb0(4'd9, 32'h9); cdb1(4'd10, 32'hA);
      tick(); cdb0(4'd11, 32'hB); cdb1(4'd12, 32'hC);
      tick(); idle();
      chk("s6_last_issue", CW'(alu_rob_id), CW'(8));
      rdy = 1'b0;
      cdb0(4'd13, 32'hD);
      disp(6'h01, 32'h0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 4'd1);
      repeat (3) begin
         tick();
         chk("s6_frozen", CW'(alu_valid), CW'(0));
         chk("s6_held_rob", CW'(alu_rob_id), CW'(8));
      end
      rdy = 1'b1; flush = 1'b1; cdb0_valid = 1'b0;
      tick(); idle();
      chk("s6_flush_full", CW'(full), CW'(0));
      repeat (4) begin
         tick();
         chk("s6_no_issue_after_flush", CW'(alu_valid), CW'(0));
      end

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         rst   = ($urandom_range(0, 999) == 0);
         flush = ($urandom_range(0, 49) == 0);
         rdy   = ($urandom_range(0, 7) != 0);
         disp_valid   = $urandom_range(0, 1) == 1;
         disp_op      = 6'($urandom);
         disp_pc      = $urandom;
         disp_vj      = $urandom;
         disp_vk      = $urandom;
         disp_imm     = $urandom;
         disp_qj_busy = ($urandom_range(0, 2) == 0);
         disp_qk_busy = ($urandom_range(0, 2) == 0);
         disp_qj      = 4'($urandom);
         disp_qk      = 4'($urandom);
         disp_rob_id  = 4'($urandom);
         cdb0_valid   = $urandom_range(0, 1) == 1;
         cdb0_rob_id  = 4'($urandom);
         cdb0_value   = $urandom;
         cdb1_valid   = $urandom_range(0, 1) == 1;
         cdb1_rob_id  = 4'($urandom);
         cdb1_value   = $urandom;
         tick();
      end
      rst = 1'b0;

      // Drain: broadcast every tag so all remaining entries issue.
      idle();
      for (int r = 0; r < 2; r++) begin
         for (int t = 0; t < 16; t++) begin
            cdb0(4'(t), $urandom);
            cdb1(4'(15 - t), $urandom);
            tick();
         end
      end
      idle();
      repeat (20) tick();
      chk("drain_scoreboard_empty", CW'(sb.size()), CW'(0));
      chk("drain_not_full", CW'(full), CW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
